// File: rtl/bus_memory.sv
// Word-addressed bus memory responder with fixed wait-state latency.
// Define BUS_MEMORY_STACK_GUARD_EN to block non-stack writes at/above STACK_LIMIT.
module bus_memory #(
  parameter int WORD_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 5,
  parameter int WAIT_STATES   = 1,
  parameter int STACK_LIMIT   = 24
) (
  input  logic                     CLK,
  input  logic                     CLR,
  input  logic                     rd,
  input  logic                     wr,
  input  logic                     Dout,
  input  logic [ADDRESS_WIDTH-1:0] Abus,
  inout  wire  [WORD_WIDTH-1:0]    Dbus,
`ifdef BUS_MEMORY_STACK_GUARD_EN
  input  logic                     stk,
  output logic                     sgv,
`endif
  output logic                     rdy,
  output logic                     busy,
  output logic                     err
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (WAIT_STATES < 0 || WAIT_STATES > 15 ||
      STACK_LIMIT < 0 || STACK_LIMIT > DEPTH) begin : g_bad_cfg
    $error("bus_memory: WAIT_STATES or STACK_LIMIT out of range");
  end

  logic [WORD_WIDTH-1:0]    mem [DEPTH];
  logic [1:0]               state;
  logic [3:0]               cnt;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [WORD_WIDTH-1:0]    wdata_q;
  logic [WORD_WIDTH-1:0]    rdata;
  logic                     op_wr;
  logic                     access;
  logic                     blocked;
  logic                     do_write;

  assign access = (state == WAIT) && (cnt == 4'd0);

`ifdef BUS_MEMORY_STACK_GUARD_EN
  localparam logic [ADDRESS_WIDTH:0] LIMIT =
    (ADDRESS_WIDTH + 1)'(STACK_LIMIT);
  logic stk_q;
  assign blocked = op_wr && !stk_q && ({1'b0, addr_q} >= LIMIT);
`else
  assign blocked = 1'b0;
`endif

  assign do_write = access && op_wr && !blocked && !CLR;

  // Read data reaches the bus in any state, so mid-access it shows the old value.
  assign Dbus = Dout ? rdata : {WORD_WIDTH{1'bz}};

  always_ff @(posedge CLK) begin
    if (do_write)
      mem[addr_q] <= wdata_q;
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      op_wr   <= 1'b0;
      rdy     <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
`ifdef BUS_MEMORY_STACK_GUARD_EN
      stk_q   <= 1'b0;
      sgv     <= 1'b0;
`endif
    end else begin
      rdy <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rd && wr) begin
            err <= 1'b1;
          end else if (rd || wr) begin
            addr_q <= Abus;
            op_wr  <= wr;
            if (wr)
              wdata_q <= Dbus;
`ifdef BUS_MEMORY_STACK_GUARD_EN
            stk_q  <= stk;
`endif
            cnt    <= 4'(WAIT_STATES);
            busy   <= 1'b1;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!op_wr)
              rdata <= mem[addr_q];
`ifdef BUS_MEMORY_STACK_GUARD_EN
            if (blocked)
              sgv <= 1'b1;
`endif
            rdy   <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_memory.sv
// Scoreboard bench for bus_memory: driver queues expectations, monitor checks on rdy.
// Set BUS_MEMORY_STACK_GUARD_EN to also exercise the stack guard.
module tb_bus_memory;

  localparam int WS = 1;

  logic       CLK = 1'b0;
  logic       CLR, rd, wr, Dout;
  logic [4:0] Abus;
  logic       drv_en;
  logic [7:0] drv_val;
  wire  [7:0] Dbus;
  logic       rdy, busy, err;
`ifdef BUS_MEMORY_STACK_GUARD_EN
  logic       stk, sgv;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] last_rd;

  typedef struct {
    bit         isrd;
    logic [7:0] data;
    int         edge_no;
  } exp_t;
  exp_t q[$];

  assign Dbus = drv_en ? drv_val : 8'hzz;

  bus_memory #(
    .WORD_WIDTH(8),
    .ADDRESS_WIDTH(5),
    .WAIT_STATES(WS),
    .STACK_LIMIT(24)
  ) dut (
    .CLK(CLK),
    .CLR(CLR),
    .rd(rd),
    .wr(wr),
    .Dout(Dout),
    .Abus(Abus),
    .Dbus(Dbus),
`ifdef BUS_MEMORY_STACK_GUARD_EN
    .stk(stk),
    .sgv(sgv),
`endif
    .rdy(rdy),
    .busy(busy),
    .err(err)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (!CLR && rdy) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rdy: got rdy=1 want 0 (cyc %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("rdy_latency", cyc, e.edge_no + 1 + WS);
        if (e.isrd)
          chk("rd_data", {24'd0, Dbus}, {24'd0, e.data});
      end
    end
  end

  // mode 0: plain, 1: disturb bus during access, 2: reset during WAIT
  task automatic do_req(input bit isrd, input logic [4:0] a,
                        input logic [7:0] d, input int mode,
                        input bit s);
    int n;
    exp_t e;
    @(negedge CLK);
    Abus = a;
`ifdef BUS_MEMORY_STACK_GUARD_EN
    stk = s;
`else
    if (s) $display("note: stk ignored without guard");
`endif
    if (isrd) begin
      rd = 1'b1;
    end else begin
      wr = 1'b1;
      Dout = 1'b0;
      drv_en = 1'b1;
      drv_val = d;
    end
    e.isrd = isrd;
    e.data = d;
    e.edge_no = cyc + 1;
    q.push_back(e);
    @(negedge CLK);
    rd = 1'b0;
    wr = 1'b0;
    drv_en = 1'b0;
    Dout = 1'b1;
    chk("busy_in_wait", {31'd0, busy}, 32'd1);
    if (isrd)
      chk("dbus_old_mid", {24'd0, Dbus}, {24'd0, last_rd});
    if (mode == 2) begin
      CLR = 1'b1;
      #2;
      CLR = 1'b0;
      e = q.pop_back();
      return;
    end
    n = 0;
    while (busy && n < 40) begin
      if (mode == 1) begin
        Abus = 5'd9;
        Dout = 1'b0;
        drv_en = 1'b1;
        drv_val = 8'hFF;
        rd = rdy;
      end
      n++;
      @(negedge CLK);
    end
    rd = 1'b0;
    drv_en = 1'b0;
    Dout = 1'b1;
    chk("busy_len", n, WS + 2);
    if (isrd)
      last_rd = d;
  endtask

  initial begin
    CLR = 1'b1;
    rd = 1'b0;
    wr = 1'b0;
    Dout = 1'b1;
    drv_en = 1'b0;
    drv_val = 8'h00;
    Abus = 5'd0;
`ifdef BUS_MEMORY_STACK_GUARD_EN
    stk = 1'b0;
`endif
    last_rd = 8'h00;
    repeat (2) @(negedge CLK);
    chk("rst_rdy", {31'd0, rdy}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rdata", {24'd0, Dbus}, 32'h00);
`ifdef BUS_MEMORY_STACK_GUARD_EN
    chk("rst_sgv", {31'd0, sgv}, 32'd0);
`endif
    CLR = 1'b0;

    do_req(0, 5'd5, 8'hA5, 0, 0);
    do_req(1, 5'd5, 8'hA5, 0, 0);
    chk("rdata_hold", {24'd0, Dbus}, 32'hA5);

    do_req(0, 5'd0, 8'h5A, 0, 0);
    do_req(0, 5'd31, 8'h3C, 0, 0);
    do_req(1, 5'd31, 8'h3C, 0, 0);
    do_req(1, 5'd0, 8'h5A, 0, 0);

    do_req(0, 5'd9, 8'h22, 0, 0);
    do_req(0, 5'd7, 8'h11, 1, 0);
    do_req(1, 5'd7, 8'h11, 0, 0);
    do_req(1, 5'd9, 8'h22, 0, 0);
    do_req(1, 5'd7, 8'h11, 0, 0);
    do_req(0, 5'd7, 8'h66, 0, 0);
    chk("wr_keeps_rdata", {24'd0, Dbus}, 32'h11);
    do_req(1, 5'd7, 8'h66, 0, 0);

    @(negedge CLK);
    Abus = 5'd5;
    rd = 1'b1;
    wr = 1'b1;
    @(negedge CLK);
    rd = 1'b0;
    wr = 1'b0;
    chk("err_set", {31'd0, err}, 32'd1);
    chk("err_no_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge CLK);
    do_req(1, 5'd5, 8'hA5, 0, 0);
    chk("err_sticky", {31'd0, err}, 32'd1);

    do_req(0, 5'd2, 8'h10, 0, 0);
    do_req(0, 5'd2, 8'h77, 2, 0);
    chk("clr_busy", {31'd0, busy}, 32'd0);
    chk("clr_err", {31'd0, err}, 32'd0);
    chk("clr_rdata", {24'd0, Dbus}, 32'h00);
    last_rd = 8'h00;
    repeat (3) @(negedge CLK);
    do_req(1, 5'd2, 8'h10, 0, 0);

`ifdef BUS_MEMORY_STACK_GUARD_EN
    chk("sgv_clear", {31'd0, sgv}, 32'd0);
    do_req(0, 5'd30, 8'h44, 0, 1);
    do_req(0, 5'd30, 8'h55, 0, 0);
    chk("sgv_set", {31'd0, sgv}, 32'd1);
    do_req(1, 5'd30, 8'h44, 0, 0);
    do_req(0, 5'd30, 8'h55, 0, 1);
    do_req(1, 5'd30, 8'h55, 0, 0);
    do_req(0, 5'd23, 8'h99, 0, 0);
    do_req(1, 5'd23, 8'h99, 0, 0);
`else
    do_req(0, 5'd30, 8'h55, 0, 0);
    do_req(1, 5'd30, 8'h55, 0, 0);
`endif

    repeat (4) @(negedge CLK);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
